// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: base-ISA major opcodes and the
// immediate-class enumeration carried through the decode stage.
package riscv_pkg;

    // Major opcodes (instr[6:0]); all legal 32-bit encodings end in 2'b11.
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Immediate class. NONE must stay at 0 so a cleared register reads NONE.
    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_Z    = 3'd6
    } imm_type_e;

endpackage

// File: rtl/imm_extend.sv
// Combinational RV32 immediate decoder and XLEN extender.
// Optional feature: define IMM_GEN_CSR_UIMM_EN to decode CSR*I forms
// (SYSTEM, funct3 101/110/111) as type Z with the 5-bit uimm in rs1.
module imm_extend
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output imm_type_e       type_o,
    output logic            illegal_o
);

    logic [31:0] imm32;
    logic        zext;

    // Classify the opcode and assemble the 32-bit immediate for its format.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise an unassigned path infers a latch.
        imm32     = '0;
        zext      = 1'b0;
        type_o    = IMM_NONE;
        illegal_o = 1'b0;

        if (instr_i[1:0] != 2'b11) begin
            illegal_o = 1'b1;
        end else begin
            case (instr_i[6:0])
                OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
                    type_o = IMM_I;
                    imm32  = {{20{instr_i[31]}}, instr_i[31:20]};
                end
                OPC_SYSTEM: begin
`ifdef IMM_GEN_CSR_UIMM_EN
                    if (instr_i[14] && (instr_i[13:12] != 2'b00)) begin
                        type_o = IMM_Z;
                        zext   = 1'b1;
                        imm32  = {27'b0, instr_i[19:15]};
                    end else begin
                        type_o = IMM_I;
                        imm32  = {{20{instr_i[31]}}, instr_i[31:20]};
                    end
`else
                    type_o = IMM_I;
                    imm32  = {{20{instr_i[31]}}, instr_i[31:20]};
`endif
                end
                OPC_STORE: begin
                    type_o = IMM_S;
                    imm32  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
                end
                OPC_BRANCH: begin
                    type_o = IMM_B;
                    imm32  = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                              instr_i[30:25], instr_i[11:8], 1'b0};
                end
                OPC_LUI, OPC_AUIPC: begin
                    type_o = IMM_U;
                    imm32  = {instr_i[31:12], 12'b0};
                end
                OPC_JAL: begin
                    type_o = IMM_J;
                    imm32  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                              instr_i[20], instr_i[30:21], 1'b0};
                end
                OPC_OP: begin
                    // Register-register ops carry no immediate but are legal.
                    type_o = IMM_NONE;
                end
                default: begin
                    illegal_o = 1'b1;
                end
            endcase
        end
    end

    // Widen to XLEN: bit 31 of every signed format is instr[31], so a signed
    // cast extends correctly; the CSR uimm is the only zero-extended case.
    always_comb begin
        if (zext) begin
            imm_o = XLEN'(imm32);
        end else begin
            imm_o = XLEN'($signed(imm32));
        end
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode pipeline stage with a two-entry skid buffer.
// Instructions are decoded at the input, buffered in a main register that
// drives the outputs, and overflow into a skid register when downstream
// stalls. in_ready is the registered inverse of skid-valid.
// Optional feature: IMM_GEN_CSR_UIMM_EN (see imm_extend).
module imm_decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_type,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        imm_type_e       typ;
        logic            illegal;
    } entry_t;

    entry_t            dec;
    entry_t            main_q, main_d;
    entry_t            skid_q, skid_d;
    logic              main_valid_q, main_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              take_in;
    logic              drain;

    imm_extend #(
        .XLEN (XLEN)
    ) u_imm_extend (
        .instr_i   (in_instr),
        .imm_o     (dec.imm),
        .type_o    (dec.typ),
        .illegal_o (dec.illegal)
    );

    assign take_in = in_valid && !skid_valid_q;
    assign drain   = main_valid_q && out_ready;

    // Next-state for the two buffer slots and the illegal counter.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        cnt_d        = cnt_q;

        if (!main_valid_q || drain) begin
            // Main frees up: the older skid entry goes first. A new input can
            // only be accepted here when skid was empty, so it goes to main.
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (take_in) begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (take_in) begin
            // Main is stalled: park the accepted entry in skid.
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end

        // Flush wins over any acceptance in the same cycle; data payloads are
        // left as-is since only the valid bits gate their use.
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end

        if (drain && main_q.illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: payload registers are reset too because they drive the
            // outputs directly and must read zero/NONE during reset.
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
            cnt_q        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready    = !skid_valid_q;
    assign out_valid   = main_valid_q;
    assign out_imm     = main_q.imm;
    assign out_type    = main_q.typ;
    assign out_illegal = main_q.illegal;
    assign illegal_cnt = cnt_q;

endmodule
